// File: rtl/conv_layer_sched_pkg.sv
// conv_layer_sched_pkg: state encoding, default sizes and watchdog helpers
// shared by the layer scheduler and its optional watchdog.
package conv_layer_sched_pkg;

  localparam int NUM_KERNELS_MAX_DEF = 16;
  localparam int TIMEOUT_CYCLES_DEF  = 1048576;
  localparam int WD_CNT_W            = 21;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_WT = 3'd1,
    CLEAR   = 3'd2,
    RUN     = 3'd3,
    WB      = 3'd4,
    DONE    = 3'd5
  } sched_state_e;

  // Counter value seen on the last permitted RUN cycle.
  function automatic logic [WD_CNT_W-1:0] wd_limit(input int timeout);
    return WD_CNT_W'(timeout - 1);
  endfunction

endpackage

// File: rtl/conv_watchdog.sv
// conv_watchdog: counts RUN cycles and flags the cycle on which the count
// reaches the timeout. Only instantiated when CONV_LAYER_SCHED_WATCHDOG_EN
// is defined.
module conv_watchdog
  import conv_layer_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic run_i,
  output logic expired_o
);

  logic [WD_CNT_W-1:0] cnt_q;

  // Cleared on the cycle before RUN, then advanced once per RUN cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (run_i) begin
      cnt_q <= cnt_q + WD_CNT_W'(1);
    end
  end

  assign expired_o = run_i && (cnt_q == wd_limit(TIMEOUT_CYCLES));

endmodule

// File: rtl/conv_layer_sched.sv
// conv_layer_sched: steps the conv engine through every kernel of one layer
// (weight load, engine clear, run, writeback handshake). All outputs are
// registered. Optional watchdog: define CONV_LAYER_SCHED_WATCHDOG_EN.
module conv_layer_sched
  import conv_layer_sched_pkg::*;
#(
  parameter int NUM_KERNELS_MAX = NUM_KERNELS_MAX_DEF,
  parameter int KCNT_W          = $clog2(NUM_KERNELS_MAX + 1),
  parameter int KIDX_W          = $clog2(NUM_KERNELS_MAX),
  parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [KCNT_W-1:0] cfg_num_kernels,
  input  logic              abort,
  output logic              busy,
  output logic              layer_done,
  output logic              wt_load_req,
  output logic [KIDX_W-1:0] wt_load_idx,
  input  logic              wt_load_ack,
  output logic              conv_clr,
  output logic              conv_en,
  input  logic              conv_done,
  output logic              wb_valid,
  output logic [KIDX_W-1:0] wb_kidx,
  input  logic              wb_ready,
  output logic              error
);

  localparam logic [KCNT_W-1:0] KMAX = KCNT_W'(NUM_KERNELS_MAX);

  // Reject timeouts the watchdog counter cannot represent.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << WD_CNT_W) - 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range for the watchdog counter");
  end

  sched_state_e      state_q;
  logic [KCNT_W-1:0] count_q;
  logic [KIDX_W-1:0] kidx_q;
  logic              busy_q, layer_done_q, wt_load_req_q, conv_clr_q, conv_en_q, wb_valid_q;
  logic [KIDX_W-1:0] wt_load_idx_q, wb_kidx_q;
  logic              last_kernel;
  logic [KIDX_W-1:0] kidx_inc;

  assign last_kernel = (KCNT_W'(kidx_q) + KCNT_W'(1)) == count_q;
  assign kidx_inc    = kidx_q + KIDX_W'(1);

`ifdef CONV_LAYER_SCHED_WATCHDOG_EN
  logic error_q;
  logic wd_expired;

  conv_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (state_q == CLEAR),
    .run_i    (state_q == RUN),
    .expired_o(wd_expired)
  );

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  // Scheduler FSM; every output is assigned here so that it leaves a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      kidx_q        <= '0;
      busy_q        <= 1'b0;
      layer_done_q  <= 1'b0;
      wt_load_req_q <= 1'b0;
      wt_load_idx_q <= '0;
      conv_clr_q    <= 1'b0;
      conv_en_q     <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_kidx_q     <= '0;
`ifdef CONV_LAYER_SCHED_WATCHDOG_EN
      error_q       <= 1'b0;
`endif
    end else begin
      layer_done_q <= 1'b0;
      conv_clr_q   <= 1'b0;
      if (abort && state_q != IDLE) begin
        // Abort beats everything, including a same-cycle writeback transfer.
        state_q       <= IDLE;
        kidx_q        <= '0;
        busy_q        <= 1'b0;
        wt_load_req_q <= 1'b0;
        wt_load_idx_q <= '0;
        conv_en_q     <= 1'b0;
        wb_valid_q    <= 1'b0;
        wb_kidx_q     <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
`ifdef CONV_LAYER_SCHED_WATCHDOG_EN
              error_q <= 1'b0;
`endif
              busy_q <= 1'b1;
              kidx_q <= '0;
              if (cfg_num_kernels == '0) begin
                state_q      <= DONE;
                layer_done_q <= 1'b1;
              end else begin
                count_q       <= (cfg_num_kernels > KMAX) ? KMAX : cfg_num_kernels;
                state_q       <= LOAD_WT;
                wt_load_req_q <= 1'b1;
                wt_load_idx_q <= '0;
              end
            end
          end
          LOAD_WT: begin
            if (wt_load_ack) begin
              state_q       <= CLEAR;
              wt_load_req_q <= 1'b0;
              wt_load_idx_q <= '0;
              conv_clr_q    <= 1'b1;
            end
          end
          CLEAR: begin
            // conv_done is deliberately not looked at here.
            state_q   <= RUN;
            conv_en_q <= 1'b1;
          end
          RUN: begin
            if (conv_done) begin
              state_q    <= WB;
              conv_en_q  <= 1'b0;
              wb_valid_q <= 1'b1;
              wb_kidx_q  <= kidx_q;
            end
`ifdef CONV_LAYER_SCHED_WATCHDOG_EN
            else if (wd_expired) begin
              state_q   <= IDLE;
              conv_en_q <= 1'b0;
              busy_q    <= 1'b0;
              kidx_q    <= '0;
              error_q   <= 1'b1;
            end
`endif
          end
          WB: begin
            if (wb_ready) begin
              wb_valid_q <= 1'b0;
              wb_kidx_q  <= '0;
              if (last_kernel) begin
                state_q      <= DONE;
                layer_done_q <= 1'b1;
              end else begin
                kidx_q        <= kidx_inc;
                state_q       <= LOAD_WT;
                wt_load_req_q <= 1'b1;
                wt_load_idx_q <= kidx_inc;
              end
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            kidx_q  <= '0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy        = busy_q;
  assign layer_done  = layer_done_q;
  assign wt_load_req = wt_load_req_q;
  assign wt_load_idx = wt_load_idx_q;
  assign conv_clr    = conv_clr_q;
  assign conv_en     = conv_en_q;
  assign wb_valid    = wb_valid_q;
  assign wb_kidx     = wb_kidx_q;

endmodule

// File: tb/tb_conv_layer_sched.sv
// tb_conv_layer_sched: scoreboard bench for the layer scheduler. Expected
// load indices, writeback indices and layer_done pulses are queued when a
// layer is started and retired as the DUT handshakes them.
module tb_conv_layer_sched;

  localparam int KCNT_W = 5;
  localparam int KIDX_W = 4;
  localparam int KMAX   = 16;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [KCNT_W-1:0] cfg_num_kernels;
  logic              abort;
  logic              busy, layer_done, wt_load_req, conv_clr, conv_en, wb_valid, error;
  logic [KIDX_W-1:0] wt_load_idx, wb_kidx;
  logic              wt_load_ack, conv_done, wb_ready;

  conv_layer_sched #(
    .NUM_KERNELS_MAX(KMAX),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .cfg_num_kernels(cfg_num_kernels),
    .abort          (abort),
    .busy           (busy),
    .layer_done     (layer_done),
    .wt_load_req    (wt_load_req),
    .wt_load_idx    (wt_load_idx),
    .wt_load_ack    (wt_load_ack),
    .conv_clr       (conv_clr),
    .conv_en        (conv_en),
    .conv_done      (conv_done),
    .wb_valid       (wb_valid),
    .wb_kidx        (wb_kidx),
    .wb_ready       (wb_ready),
    .error          (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] outs();
    return {17'd0, busy, layer_done, wt_load_req, wt_load_idx, conv_clr,
            conv_en, wb_valid, wb_kidx, error};
  endfunction

  // Scoreboard queues
  int exp_load[$];
  int exp_wb[$];
  int exp_done[$];

  // Responder configuration
  int ack_delay  = 0;
  int done_delay = 1;
  bit done_never = 0;
  int stall_kidx = -1;
  int stall_len  = 0;

  // Monitor state
  int load_hs_cnt = 0, wb_hs_cnt = 0, done_cnt = 0, last_done_cyc = 0;
  int stall_obs = 0, en_cycles = 0, start_cyc = 0;
  bit activity = 0;

  // Responder: weight buffer, conv engine and writeback consumer models.
  initial begin
    int ack_cnt, run_cnt, wb_cnt;
    ack_cnt = 0; run_cnt = 0; wb_cnt = 0;
    wt_load_ack = 1'b0; conv_done = 1'b0; wb_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (wt_load_req) begin
        if (ack_cnt >= ack_delay) wt_load_ack = 1'b1;
        else ack_cnt++;
      end else begin
        wt_load_ack = 1'b0; ack_cnt = 0;
      end
      if (conv_en && !done_never) begin
        if (run_cnt >= done_delay - 1) conv_done = 1'b1;
        else run_cnt++;
      end else begin
        conv_done = 1'b0; run_cnt = 0;
      end
      if (wb_valid) begin
        if (int'(wb_kidx) == stall_kidx && wb_cnt < stall_len) begin
          wb_ready = 1'b0; wb_cnt++;
        end else begin
          wb_ready = 1'b1;
        end
      end else begin
        wb_ready = 1'b0; wb_cnt = 0;
      end
    end
  end

  // Monitor: samples 2 time units after the falling edge, once inputs settle.
  initial begin
    logic            prev_stall, prev_clr;
    logic [KIDX_W-1:0] prev_kidx;
    int e;
    prev_stall = 1'b0; prev_clr = 1'b0; prev_kidx = '0;
    forever begin
      @(negedge clk); #2;
      if (!reset_n) begin
        prev_stall = 1'b0; prev_clr = 1'b0;
        continue;
      end
      if (wt_load_req || conv_en || wb_valid) activity = 1;
      if (conv_en) en_cycles++;
      if (prev_clr) chk("clr_then_en", {30'd0, conv_clr, conv_en}, 32'd1);
      prev_clr = conv_clr && !abort;
      if (wt_load_req && wt_load_ack && !abort) begin
        load_hs_cnt++;
        e = (exp_load.size() > 0) ? exp_load.pop_front() : 32'hDEAD;
        $display("load   idx=%0d exp=%0d cycle=%0d", wt_load_idx, e, cyc);
        chk("load_idx", 32'(wt_load_idx), e);
      end
      if (prev_stall) chk("wb_hold", {27'd0, wb_valid, wb_kidx}, {27'd0, 1'b1, prev_kidx});
      if (wb_valid) chk("wb_no_conv_en", 32'(conv_en), 32'd0);
      if (wb_valid && !wb_ready) stall_obs++;
      prev_stall = wb_valid && !wb_ready && !abort;
      prev_kidx  = wb_kidx;
      if (wb_valid && wb_ready && !abort) begin
        wb_hs_cnt++;
        e = (exp_wb.size() > 0) ? exp_wb.pop_front() : 32'hDEAD;
        $display("wb     kidx=%0d exp=%0d cycle=%0d", wb_kidx, e, cyc);
        chk("wb_kidx", 32'(wb_kidx), e);
      end
      if (layer_done) begin
        done_cnt++;
        last_done_cyc = cyc;
        e = (exp_done.size() > 0) ? exp_done.pop_front() : 0;
        $display("done   layer cycle=%0d", cyc);
        chk("layer_done_expected", 32'(layer_done), e);
        chk("busy_at_done", 32'(busy), 32'd1);
      end
    end
  end

  task automatic start_layer(input int n);
    int eff;
    eff = (n > KMAX) ? KMAX : n;
    @(negedge clk);
    start = 1'b1;
    cfg_num_kernels = KCNT_W'(n);
    start_cyc = cyc;
    for (int i = 0; i < eff; i++) begin
      exp_load.push_back(i);
      exp_wb.push_back(i);
    end
    exp_done.push_back(1);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for the next layer_done; returns the inclusive latency.
  task automatic wait_done(input int c0, input int budget, output int lat);
    int i;
    i = 0;
    while (done_cnt == c0 && i < budget) begin
      @(negedge clk); #3;
      i++;
    end
    chk("done_seen", 32'(done_cnt - c0), 32'd1);
    lat = last_done_cyc - start_cyc + 1;
    @(negedge clk); #3;
    chk("busy_fall", 32'(busy), 32'd0);
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_load_left"}, 32'(exp_load.size()), 32'd0);
    chk({tag, "_wb_left"}, 32'(exp_wb.size()), 32'd0);
    chk({tag, "_done_left"}, 32'(exp_done.size()), 32'd0);
  endtask

  task automatic flush();
    exp_load.delete(); exp_wb.delete(); exp_done.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int c0, ld0, wb0, lat, i;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_num_kernels = '0;
    repeat (3) @(negedge clk);
    #3 chk("rst_outputs", outs(), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk); #3 chk("idle_after_rst", outs(), 32'd0);

    // 1: three kernels, ack after 2, conv_done after 10 RUN cycles
    ack_delay = 2; done_delay = 10;
    c0 = done_cnt; ld0 = load_hs_cnt; wb0 = wb_hs_cnt;
    start_layer(3);
    wait_done(c0, 500, lat);
    chk("t1_loads", 32'(load_hs_cnt - ld0), 32'd3);
    chk("t1_wbs", 32'(wb_hs_cnt - wb0), 32'd3);
    check_drained("t1");

    // 2: zero kernels -> straight to DONE
    activity = 0; c0 = done_cnt;
    start_layer(0);
    wait_done(c0, 20, lat);
    chk("t2_latency", 32'(lat), 32'd2);
    chk("t2_no_activity", 32'(activity), 32'd0);
    check_drained("t2");

    // Single kernel, zero-wait handshakes, conv_done after 4 RUN cycles
    ack_delay = 0; done_delay = 4; c0 = done_cnt;
    start_layer(1);
    wait_done(c0, 50, lat);
    chk("min_latency", 32'(lat), 32'd9);
    check_drained("t1k");

    // 3: writeback stall of 7 cycles on kernel 1
    ack_delay = 1; done_delay = 3; stall_kidx = 1; stall_len = 7;
    stall_obs = 0; c0 = done_cnt;
    start_layer(3);
    wait_done(c0, 500, lat);
    chk("t3_stall_cycles", 32'(stall_obs), 32'd7);
    check_drained("t3");
    stall_kidx = -1; stall_len = 0;

    // Count above the maximum clamps to 16 kernels
    ack_delay = 0; done_delay = 2; c0 = done_cnt; ld0 = load_hs_cnt;
    start_layer(20);
    wait_done(c0, 2000, lat);
    chk("clamp_loads", 32'(load_hs_cnt - ld0), 32'd16);
    check_drained("clamp");

    // 4: abort in RUN of the second kernel of four
    done_delay = 10; c0 = done_cnt; ld0 = load_hs_cnt;
    start_layer(4);
    i = 0;
    while (!(conv_en && load_hs_cnt == ld0 + 2) && i < 500) begin
      @(negedge clk); #3; i++;
    end
    chk("t4_reached_run", 32'(conv_en), 32'd1);
    abort = 1'b1;
    @(negedge clk); #3;
    chk("t4_abort_outputs", outs(), 32'd0);
    abort = 1'b0;
    flush();
    repeat (3) @(negedge clk);
    #3 chk("t4_no_layer_done", 32'(done_cnt - c0), 32'd0);
    c0 = done_cnt;
    start_layer(1);
    wait_done(c0, 200, lat);
    check_drained("t4");

    // 5: asynchronous reset in the middle of a writeback stall
    done_delay = 3; stall_kidx = 0; stall_len = 5;
    start_layer(2);
    i = 0;
    while (!wb_valid && i < 200) begin
      @(negedge clk); #3; i++;
    end
    chk("t5_reached_wb", 32'(wb_valid), 32'd1);
    #1 reset_n = 1'b0;
    #1 chk("t5_async_reset", outs(), 32'd0);
    @(negedge clk); start = 1'b1; cfg_num_kernels = KCNT_W'(1);
    @(negedge clk); start = 1'b0;
    #3 chk("t5_start_in_reset", outs(), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    flush(); stall_kidx = -1; stall_len = 0;
    @(negedge clk); #3 chk("t5_idle_after_release", outs(), 32'd0);

`ifdef CONV_LAYER_SCHED_WATCHDOG_EN
    // 6: conv_done never arrives -> watchdog error after 64 RUN cycles
    done_never = 1; en_cycles = 0; c0 = done_cnt;
    start_layer(1);
    i = 0;
    while (!error && i < 300) begin
      @(negedge clk); #3; i++;
    end
    chk("t6_error", 32'(error), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_run_cycles", 32'(en_cycles), 32'd64);
    chk("t6_no_layer_done", 32'(done_cnt - c0), 32'd0);
    flush(); done_never = 0; c0 = done_cnt;
    start_layer(1);
    #3 chk("t6_error_cleared", 32'(error), 32'd0);
    wait_done(c0, 200, lat);
    check_drained("t6");
`else
    chk("error_tied_low", 32'(error), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
